// File: rtl/fp16_mul_seq.sv
// Biased-exponent adder: eA + eB - 15 + inc, as a 7-bit signed sum.
// Combinational, no latency.
// No flow control.
module csa (
    input  logic              [4:0] ea,
    input  logic              [4:0] eb,
    input  logic                    inc,
    output logic signed       [6:0] sum
);
    localparam logic [6:0] BIAS_NEG = 7'b1110001;   // -15 in 7-bit two's complement

    logic [6:0] x, y, s, c;

    assign x   = {2'b00, ea};
    assign y   = {2'b00, eb};
    assign s   = x ^ y ^ BIAS_NEG;
    assign c   = {(x[5:0] & y[5:0]) | (x[5:0] & BIAS_NEG[5:0]) | (y[5:0] & BIAS_NEG[5:0]), 1'b0};
    assign sum = signed'(s + c + {6'b0, inc});
endmodule

// Sequential FP16 multiplier: unpack, special-case, 11-cycle shift-add, normalize.
// Latency 13 cycles for normal operands, 1 cycle for special operands.
// Accepts only in IDLE; holds result and flags in DONE until out_ready.
module fp16_mul_seq #(
    parameter int MUL_CYCLES = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        inv
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t             state;
    logic               sign;
    logic [4:0]         exp_a, exp_b;
    logic [21:0]        mcand, acc;
    logic [10:0]        mplier;
    logic [CW-1:0]      cnt;

    logic               a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic               inc;
    logic [9:0]         frac;
    logic signed [6:0]  exp_sum;
    logic               unused_lsbs;

    assign a_nan  = (&a[14:10]) &  (|a[9:0]);
    assign a_inf  = (&a[14:10]) & ~(|a[9:0]);
    assign a_zero = ~(|a[14:10]);
    assign b_nan  = (&b[14:10]) &  (|b[9:0]);
    assign b_inf  = (&b[14:10]) & ~(|b[9:0]);
    assign b_zero = ~(|b[14:10]);

    assign in_ready    = (state == IDLE);
    assign inc         = acc[21];
    assign frac        = inc ? acc[20:11] : acc[19:10];
    // Product bits below the kept fraction are truncated away.
    assign unused_lsbs = ^acc[9:0];

    csa u_csa (
        .ea  (exp_a),
        .eb  (exp_b),
        .inc (inc),
        .sum (exp_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= 16'h0000;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inv       <= 1'b0;
            sign      <= 1'b0;
            exp_a     <= 5'd0;
            exp_b     <= 5'd0;
            mcand     <= 22'd0;
            mplier    <= 11'd0;
            acc       <= 22'd0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign   <= a[15] ^ b[15];
                        exp_a  <= a[14:10];
                        exp_b  <= b[14:10];
                        mcand  <= {11'd0, 1'b1, a[9:0]};
                        mplier <= {1'b1, b[9:0]};
                        acc    <= 22'd0;
                        cnt    <= '0;
                        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                            result    <= 16'h7E00;
                            inv       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (a_inf || b_inf) begin
                            result    <= {a[15] ^ b[15], 15'h7C00};
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (a_zero || b_zero) begin
                            result    <= {a[15] ^ b[15], 15'h0000};
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(MUL_CYCLES - 1)) state <= NORM;
                end
                NORM: begin
                    if (exp_sum >= 7'sd31) begin
                        result <= {sign, 15'h7C00};
                        ovf    <= 1'b1;
                    end else if (exp_sum <= 7'sd0) begin
                        result <= {sign, 15'h0000};
                        unf    <= 1'b1;
                    end else begin
                        result <= {sign, exp_sum[4:0], frac};
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ovf       <= 1'b0;
                        unf       <= 1'b0;
                        inv       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_mul_seq.sv
// Bench for fp16_mul_seq: directed vectors, backpressure, reset abort, random ops vs an arithmetic model.
module tb_fp16_mul_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, ovf, unf, inv;
    logic [15:0] a, b, result;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fp16_mul_seq #(.MUL_CYCLES(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .inv       (inv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {inv, ovf, unf, result} from the FP16 rules with plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
        int ex, ey, fx, fy, e, f, p;
        bit s, nx, ny, ix, iy, zx, zy;
        ex = int'(x[14:10]); fx = int'(x[9:0]);
        ey = int'(y[14:10]); fy = int'(y[9:0]);
        s  = x[15] ^ y[15];
        nx = (ex == 31) && (fx != 0); ix = (ex == 31) && (fx == 0); zx = (ex == 0);
        ny = (ey == 31) && (fy != 0); iy = (ey == 31) && (fy == 0); zy = (ey == 0);
        if (nx || ny || (ix && zy) || (iy && zx)) return {3'b100, 16'h7E00};
        if (ix || iy) return {3'b000, s, 15'h7C00};
        if (zx || zy) return {3'b000, s, 15'h0000};
        p = (1024 + fx) * (1024 + fy);
        e = ex + ey - 15;
        if (p >= (1 << 21)) begin
            e = e + 1;
            f = (p >> 11) % 1024;
        end else begin
            f = (p >> 10) % 1024;
        end
        if (e >= 31) return {3'b010, s, 15'h7C00};
        if (e <= 0)  return {3'b001, s, 15'h0000};
        return {3'b000, s, 5'(e), 10'(f)};
    endfunction

    function automatic bit is_special(input logic [15:0] x, input logic [15:0] y);
        return (x[14:10] == 5'd31) || (x[14:10] == 5'd0) || (y[14:10] == 5'd31) || (y[14:10] == 5'd0);
    endfunction

    task automatic accept(input logic [15:0] xa, input logic [15:0] xb);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                          input logic [15:0] er, input logic [2:0] ef, input int elat, input int hold);
        int lat;
        logic [15:0] held;
        accept(xa, xb);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_res"}, 32'(result), 32'(er));
        check({tag, "_flags"}, 32'({inv, ovf, unf}), 32'(ef));
        held = result;
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold"}, 32'({out_valid, in_ready, inv, ovf, unf, result}),
                  32'({1'b1, 1'b0, ef, held}));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'({in_ready, out_valid, inv, ovf, unf}), 32'(5'b10000));
    endtask

    logic [15:0] va [7] = '{16'h3C00, 16'h3E00, 16'hBC00, 16'h7BFF, 16'h0400, 16'h7C00, 16'hFC00};
    logic [15:0] vb [7] = '{16'h3C00, 16'h3E00, 16'h4000, 16'h7BFF, 16'h0400, 16'h0000, 16'h4000};
    logic [15:0] vr [7] = '{16'h3C00, 16'h4080, 16'hC000, 16'h7C00, 16'h0000, 16'h7E00, 16'hFC00};
    logic [2:0]  vf [7] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000};
    int          vl [7] = '{13, 13, 13, 13, 13, 1, 1};

    initial begin
        int lat, seen;
        logic [15:0] held, xa, xb;
        logic [18:0] m;

        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; a = 16'h3C00; b = 16'h3C00; out_ready = 1'b0;
        step();
        step();
        check("reset_ctl", 32'({in_ready, out_valid, ovf, unf, inv}), 32'(5'b10000));
        check("reset_result", 32'(result), 32'h0);
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        check("post_reset_idle", 32'({in_ready, out_valid}), 32'(2'b10));

        for (int i = 0; i < 7; i++)
            run_op($sformatf("dir%0d", i), va[i], vb[i], vr[i], vf[i], vl[i], 2);

        // Backpressure with a pending operand pair.
        accept(16'h3E00, 16'h3C00);
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'd13);
        m = model(16'h3E00, 16'h3C00);
        check("bp_res", 32'(result), 32'(m[15:0]));
        held = result;
        a = 16'h4000; b = 16'h4200; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_hold", 32'({out_valid, in_ready, result}), 32'({1'b1, 1'b0, held}));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_idle", 32'({in_ready, out_valid}), 32'(2'b10));
        step();
        in_valid = 1'b0;
        check("bp_new_accepted", 32'(in_ready), 32'd0);
        wait_result(lat);
        check("bp_new_lat", 32'(lat), 32'd13);
        m = model(16'h4000, 16'h4200);
        check("bp_new_res", 32'(result), 32'(m[15:0]));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the sixth MUL cycle aborts the op silently.
        accept(16'h3C00, 16'h3C00);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ctl", 32'({out_valid, in_ready}), 32'(2'b01));
        check("abort_result", 32'(result), 32'h0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("abort_silent", 32'(seen), 32'd0);
        run_op("after_rst", 16'h3C00, 16'h3C00, 16'h3C00, 3'b000, 13, 0);

        // Randomized operands against the model.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: begin xa = 16'($urandom); xb = 16'($urandom); end
                1: begin
                    xa = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
                    xb = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
                end
                2: begin
                    xa = {1'($urandom), ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0,
                          ($urandom_range(0, 1) != 0) ? 10'd0 : 10'($urandom)};
                    xb = 16'($urandom);
                end
                default: begin
                    xa = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
                    xb = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
                end
            endcase
            m = model(xa, xb);
            run_op($sformatf("rnd%0d_%04h_%04h", i, xa, xb), xa, xb, m[15:0], m[18:16],
                   is_special(xa, xb) ? 1 : 13, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
